// File: rtl/adaptive_lif_neuron_if.sv
// rtl/adaptive_lif_neuron_if.sv - timestep handshake, spike inputs, weight port and neuron outputs
interface adaptive_lif_neuron_if #(
    parameter int NUM_FAN_IN = 8,
    parameter int NUM_REC_IN = 8,
    parameter int STATE_W    = 8,
    parameter int WEIGHT_W   = 4
);
    localparam int N      = NUM_FAN_IN + NUM_REC_IN;
    localparam int ADDR_W = $clog2(N);

    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_FAN_IN-1:0] fan_in;
    logic [NUM_REC_IN-1:0] rec_spk;
    logic                  w_we;
    logic [ADDR_W-1:0]     w_addr;
    logic [WEIGHT_W-1:0]   w_data;
    logic                  spk;
    logic                  out_valid;
    logic [STATE_W-1:0]    mem_out;

    modport master (
        output in_valid, fan_in, rec_spk, w_we, w_addr, w_data,
        input  in_ready, spk, out_valid, mem_out
    );

    modport slave (
        input  in_valid, fan_in, rec_spk, w_we, w_addr, w_data,
        output in_ready, spk, out_valid, mem_out
    );
endinterface

// File: rtl/adaptive_lif_neuron.sv
// rtl/adaptive_lif_neuron.sv - adaptive LIF neuron with serial weighted integration and refractory hold
module adaptive_lif_neuron #(
    parameter int NUM_FAN_IN      = 8,
    parameter int NUM_REC_IN      = 8,
    parameter int STATE_W         = 8,
    parameter int WEIGHT_W        = 4,
    parameter int ORI_THR         = 32,
    parameter int DECAY_SHIFT_CUR = 2,
    parameter int DECAY_SHIFT_MEM = 2,
    parameter int DECAY_SHIFT_THR = 2,
    parameter int ADP_THR         = 2,
    parameter int REFRAC_STEPS    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    adaptive_lif_neuron_if.slave bus
);
    localparam int N      = NUM_FAN_IN + NUM_REC_IN;
    localparam int ADDR_W = $clog2(N);
    localparam int ACC_W  = WEIGHT_W + $clog2(N + 1);
    localparam int EXT_W  = STATE_W + 2;
    localparam int REF_W  = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

    localparam logic signed [EXT_W-1:0] CUR_MAX = EXT_W'((2 ** (STATE_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] CUR_MIN = EXT_W'(-(2 ** (STATE_W - 1)));
    localparam logic signed [EXT_W-1:0] THR_MAX = EXT_W'((2 ** STATE_W) - 1);
    localparam logic signed [EXT_W-1:0] THR_MIN = EXT_W'(ORI_THR);
    localparam logic signed [EXT_W-1:0] ADP_EXT = EXT_W'(ADP_THR);
    localparam logic signed [EXT_W-1:0] ZERO    = '0;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE} state_t;

    state_t                     r_state;
    logic [N-1:0]               r_spikes;
    logic [ADDR_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [WEIGHT_W-1:0] r_weight [N];
    logic signed [STATE_W-1:0]  r_cur;
    logic signed [STATE_W-1:0]  r_mem;
    logic [STATE_W-1:0]         r_thr;
    logic [REF_W-1:0]           r_refrac;
    logic                       r_spk;
    logic                       r_out_valid;
    logic                       r_in_ready;

    logic signed [WEIGHT_W-1:0] w_weight;
    logic signed [ACC_W-1:0]    w_weight_ext;
    logic signed [EXT_W-1:0]    w_acc_ext, w_cur_ext, w_mem_ext, w_thr_ext, w_adp;
    logic signed [EXT_W-1:0]    w_cur_sum, w_mem_sum, w_thr_sum;
    logic signed [STATE_W-1:0]  w_cur_next, w_mem_next;
    logic [STATE_W-1:0]         w_thr_next;
    logic                       w_spk_new;
    logic                       w_addr_ok;

    assign w_weight     = r_weight[r_idx];
    assign w_weight_ext = {{(ACC_W - WEIGHT_W){w_weight[WEIGHT_W-1]}}, w_weight};

    assign w_acc_ext = {{(EXT_W - ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_cur_ext = {{2{r_cur[STATE_W-1]}}, r_cur};
    assign w_mem_ext = {{2{r_mem[STATE_W-1]}}, r_mem};
    assign w_thr_ext = {2'b00, r_thr};

    assign w_spk_new = (w_mem_ext >= w_thr_ext) && (r_refrac == '0);
    assign w_adp     = w_spk_new ? ADP_EXT : ZERO;

    // Sums are formed two bits wider than the state so the clamps see the true value.
    assign w_cur_sum = w_acc_ext + w_cur_ext - (w_cur_ext >>> DECAY_SHIFT_CUR);
    assign w_mem_sum = w_cur_ext + w_mem_ext - (w_mem_ext >>> DECAY_SHIFT_MEM);
    assign w_thr_sum = w_thr_ext + w_adp - ((w_thr_ext - THR_MIN) >>> DECAY_SHIFT_THR);

    always_comb begin
        w_cur_next = w_cur_sum[STATE_W-1:0];
        if (w_cur_sum > CUR_MAX)
            w_cur_next = CUR_MAX[STATE_W-1:0];
        else if (w_cur_sum < CUR_MIN)
            w_cur_next = CUR_MIN[STATE_W-1:0];

        w_mem_next = w_mem_sum[STATE_W-1:0];
        if (w_mem_sum > CUR_MAX)
            w_mem_next = CUR_MAX[STATE_W-1:0];
        else if (w_mem_sum < ZERO)
            w_mem_next = '0;

        w_thr_next = w_thr_sum[STATE_W-1:0];
        if (w_thr_sum > THR_MAX)
            w_thr_next = THR_MAX[STATE_W-1:0];
        else if (w_thr_sum < THR_MIN)
            w_thr_next = THR_MIN[STATE_W-1:0];
    end

    assign w_addr_ok = {1'b0, bus.w_addr} < (ADDR_W + 1)'(N);

    // A write landing on the index being read this cycle only becomes visible next cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++)
                r_weight[i] <= WEIGHT_W'(1);
        end else if (bus.w_we && w_addr_ok) begin
            r_weight[bus.w_addr] <= bus.w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_spikes    <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_cur       <= '0;
            r_mem       <= '0;
            r_thr       <= STATE_W'(ORI_THR);
            r_refrac    <= '0;
            r_spk       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_spikes   <= {bus.rec_spk, bus.fan_in};
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (r_spikes[r_idx])
                        r_acc <= r_acc + w_weight_ext;
                    r_idx <= r_idx + ADDR_W'(1);
                    if (r_idx == ADDR_W'(N - 1))
                        r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_spk <= w_spk_new;
                    r_cur <= w_cur_next;
                    r_thr <= w_thr_next;
                    if (w_spk_new || (r_refrac != '0))
                        r_mem <= '0;
                    else
                        r_mem <= w_mem_next;
                    if (w_spk_new)
                        r_refrac <= REF_W'(REFRAC_STEPS);
                    else if (r_refrac != '0)
                        r_refrac <= r_refrac - REF_W'(1);
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.spk       = r_spk;
    assign bus.out_valid = r_out_valid;
    assign bus.mem_out   = r_mem;
endmodule

// File: tb/tb_adaptive_lif_neuron.sv
// tb/tb_adaptive_lif_neuron.sv - directed bench with per-cycle reference model for adaptive_lif_neuron
module tb_adaptive_lif_neuron;
    localparam int N = 16;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    adaptive_lif_neuron_if #(.NUM_FAN_IN(8), .NUM_REC_IN(8), .STATE_W(8), .WEIGHT_W(4)) bus ();

    adaptive_lif_neuron #(
        .NUM_FAN_IN(8), .NUM_REC_IN(8), .STATE_W(8), .WEIGHT_W(4), .ORI_THR(32),
        .DECAY_SHIFT_CUR(2), .DECAY_SHIFT_MEM(2), .DECAY_SHIFT_THR(2),
        .ADP_THR(2), .REFRAC_STEPS(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: neuron state as plain integers, weights as a timestamped write log.
    typedef struct {int at; int addr; int data;} wr_t;
    wr_t         wlog[$];
    int          m_cur, m_mem, m_thr, m_ref;
    int          m_spk;
    bit          p_busy;
    int          p_at;
    logic [15:0] p_spikes;
    bit          rst_pending;
    bit          model_on;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int weight_at(input int addr, input int t);
        int w = 1;
        foreach (wlog[k])
            if (wlog[k].addr == addr && wlog[k].at <= t)
                w = wlog[k].data;
        return w;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_mem = 0; m_thr = 32; m_ref = 0; m_spk = 0;
        wlog.delete();
        p_busy = 0;
    endtask

    task automatic model_step();
        int acc = 0;
        int spk_new, cur_n, mem_n, thr_n, ref_n;
        for (int i = 0; i < N; i++)
            if (p_spikes[i])
                acc += weight_at(i, p_at + i);
        spk_new = (m_mem >= m_thr && m_ref == 0) ? 1 : 0;
        cur_n   = clampi(acc + m_cur - (m_cur >>> 2), -128, 127);
        mem_n   = (spk_new == 1 || m_ref != 0) ? 0 : clampi(m_cur + m_mem - (m_mem >>> 2), 0, 127);
        thr_n   = clampi(m_thr + (spk_new == 1 ? 2 : 0) - ((m_thr - 32) >>> 2), 32, 255);
        ref_n   = (spk_new == 1) ? 2 : ((m_ref > 0) ? m_ref - 1 : 0);
        m_cur = cur_n; m_mem = mem_n; m_thr = thr_n; m_ref = ref_n; m_spk = spk_new;
    endtask

    initial begin
        rst_pending = 0; model_on = 0; p_busy = 0;
    end

    always @(negedge clk) begin
        bit exp_ov;
        if (rst_pending) begin
            model_reset();
            rst_pending = 0;
            model_on = 1;
        end
        if (model_on) begin
            exp_ov = p_busy && (cyc == p_at + N + 1);
            if (exp_ov) begin
                model_step();
                p_busy = 0;
            end
            chk("out_valid", int'(bus.out_valid), int'(exp_ov));
            chk("in_ready", int'(bus.in_ready), p_busy ? 0 : 1);
            chk("spk", int'(bus.spk), m_spk);
            chk("mem_out", int'(bus.mem_out), m_mem);
            chk("cur", int'($signed(dut.r_cur)), m_cur);
            chk("thr", int'(dut.r_thr), m_thr);
        end
        if (reset_n !== 1'b1) begin
            rst_pending = 1;
            p_busy = 0;
        end else if (model_on) begin
            if (!p_busy && bus.in_valid) begin
                p_busy   = 1;
                p_at     = cyc + 1;
                p_spikes = {bus.rec_spk, bus.fan_in};
            end
            if (bus.w_we && int'(bus.w_addr) < N)
                wlog.push_back('{cyc + 1, int'(bus.w_addr), int'($signed(bus.w_data))});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.w_we     = 1'b0;
        reset_n      = 1'b0;
        tick(2);
        reset_n      = 1'b1;
    endtask

    task automatic write_w(input int addr, input logic [3:0] data);
        bus.w_we   = 1'b1;
        bus.w_addr = 4'(addr);
        bus.w_data = data;
        tick(1);
        bus.w_we   = 1'b0;
    endtask

    task automatic wait_out();
        int k = 0;
        while (!bus.out_valid && k < 40) begin
            tick(1);
            k++;
        end
        if (!bus.out_valid)
            chk("out_valid_timeout", 0, 1);
    endtask

    task automatic do_step(input logic [7:0] fan, input logic [7:0] rec, output int latency);
        int a;
        for (int k = 0; k < 40 && !bus.in_ready; k++)
            tick(1);
        if (!bus.in_ready)
            chk("in_ready_timeout", 0, 1);
        bus.fan_in   = fan;
        bus.rec_spk  = rec;
        bus.in_valid = 1'b1;
        a = cyc + 1;
        tick(1);
        bus.in_valid = 1'b0;
        bus.fan_in   = 8'($urandom);
        bus.rec_spk  = 8'($urandom);
        wait_out();
        latency = cyc - a;
    endtask

    initial begin
        int lat, n_out, last;
        n_checks = 0; n_fail = 0;
        bus.in_valid = 1'b0; bus.fan_in = '0; bus.rec_spk = '0;
        bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0;
        reset_n = 1'b0;

        do_reset();
        chk("rst_spk", int'(bus.spk), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_mem_out", int'(bus.mem_out), 0);
        do_step(8'h00, 8'h00, lat);
        chk("latency", lat, N + 1);
        chk("zero_step_spk", int'(bus.spk), 0);
        chk("zero_step_mem", int'(bus.mem_out), 0);

        do_reset();
        do_step(8'h0F, 8'h00, lat);
        chk("count1_cur", int'($signed(dut.r_cur)), 4);
        chk("count1_mem", int'(bus.mem_out), 0);
        do_step(8'h0F, 8'h00, lat);
        chk("count2_cur", int'($signed(dut.r_cur)), 7);
        chk("count2_mem", int'(bus.mem_out), 4);

        do_reset();
        for (int i = 0; i < 8; i++) write_w(i, 4'd7);
        do_step(8'hFF, 8'h00, lat);
        do_step(8'hFF, 8'h00, lat);
        chk("pre_spike_mem", int'(bus.mem_out), 56);
        do_step(8'hFF, 8'h00, lat);
        chk("spike_spk", int'(bus.spk), 1);
        chk("spike_mem", int'(bus.mem_out), 0);
        chk("spike_thr", int'(dut.r_thr), 34);
        chk("spike_cur_sat", int'($signed(dut.r_cur)), 127);
        for (int s = 0; s < 2; s++) begin
            do_step(8'hFF, 8'h00, lat);
            chk("refrac_spk", int'(bus.spk), 0);
            chk("refrac_mem", int'(bus.mem_out), 0);
        end
        do_step(8'hFF, 8'h00, lat);
        chk("post_refrac_mem", int'(bus.mem_out), 127);

        do_reset();
        for (int i = 0; i < N; i++) write_w(i, 4'h8);
        do_step(8'hFF, 8'hFF, lat);
        chk("neg1_cur", int'($signed(dut.r_cur)), -128);
        chk("neg1_mem", int'(bus.mem_out), 0);
        do_step(8'hFF, 8'hFF, lat);
        chk("neg2_cur", int'($signed(dut.r_cur)), -128);
        chk("neg2_mem", int'(bus.mem_out), 0);

        do_reset();
        bus.fan_in = 8'h0F; bus.rec_spk = 8'h01; bus.in_valid = 1'b1;
        n_out = 0; last = -1;
        for (int t = 0; t < 72; t++) begin
            tick(1);
            if (bus.out_valid) begin
                n_out++;
                if (last >= 0) chk("ov_period", cyc - last, N + 2);
                last = cyc;
            end
        end
        bus.in_valid = 1'b0;
        chk("ov_count", n_out, 4);

        do_reset();
        bus.fan_in = 8'hFF; bus.rec_spk = 8'h00; bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
        tick(5);
        bus.w_we = 1'b1; bus.w_addr = 4'd5; bus.w_data = 4'hD;
        tick(1);
        bus.w_we = 1'b0;
        wait_out();
        chk("wr_race_old_cur", int'($signed(dut.r_cur)), 8);
        do_step(8'hFF, 8'h00, lat);
        chk("wr_race_new_cur", int'($signed(dut.r_cur)), 10);
        chk("wr_race_new_mem", int'(bus.mem_out), 8);

        do_reset();
        write_w(0, 4'd5);
        bus.fan_in = 8'hFF; bus.rec_spk = 8'hFF; bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
        tick(6);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        n_out = 0;
        for (int t = 0; t < 25; t++) begin
            tick(1);
            if (bus.out_valid) n_out++;
        end
        chk("abort_no_out_valid", n_out, 0);
        chk("abort_spk", int'(bus.spk), 0);
        chk("abort_mem", int'(bus.mem_out), 0);
        chk("abort_in_ready", int'(bus.in_ready), 1);
        do_step(8'hFF, 8'hFF, lat);
        chk("abort_weights_reset_cur", int'($signed(dut.r_cur)), 16);

        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
